// File: rtl/muldiv_unit_if.sv
// rtl/muldiv_unit_if.sv - request/result bundle between the core controller and muldiv_unit
// Signals:
//   start, op[1:0], a, b      operation request (op: 00 mult, 01 multu, 10 div, 11 divu)
//   hi_we, lo_we, wdata       direct HI/LO writes (mthi/mtlo)
//   busy, done                unit status; done pulses once per finished operation
//   hi, lo                    architectural HI/LO registers
// master: the controller side; slave: the multiply/divide unit.
interface muldiv_unit_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             hi_we;
  logic             lo_we;
  logic [WIDTH-1:0] wdata;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, hi_we, lo_we, wdata,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, hi_we, lo_we, wdata,
    output busy, done, hi, lo
  );
endinterface

// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative radix-2 multiply/divide unit owning the HI/LO registers
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; aborts any operation, clears HI/LO
//   bus.slave  start/op/a/b request, hi_we/lo_we/wdata direct writes,
//              busy/done status and hi/lo result registers
// One shift-add or restoring-divide step per cycle on operand magnitudes;
// the sign is applied once, in FIN, when HI/LO are written.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic         clk,
  input  logic         rst,
  muldiv_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      count;
  // mul: {accumulator high half, multiplier shifting out}
  // div: {partial remainder, dividend shifting out / quotient shifting in}
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   opnd;     // multiplicand magnitude or divisor magnitude
  logic               is_div;
  logic               neg_lo;   // negate product (mul) or quotient (div)
  logic               neg_hi;   // negate remainder (div only)
  logic               dz_hold;  // divide-by-zero spends one extra FIN cycle

  logic               sgn_op, a_neg, b_neg, b_zero;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     mul_sum, div_shift, div_diff;
  logic [2*WIDTH-1:0] mul_next, div_next, prod_neg;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

  assign bus.busy = (state != IDLE);

  always_comb begin
    sgn_op = ~bus.op[0];
    a_neg  = sgn_op & bus.a[WIDTH-1];
    b_neg  = sgn_op & bus.b[WIDTH-1];
    // Magnitudes are kept as WIDTH-bit unsigned so -2^(W-1) maps to 2^(W-1).
    mag_a  = a_neg ? -bus.a : bus.a;
    mag_b  = b_neg ? -bus.b : bus.b;
    b_zero = (bus.b == '0);

    mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, opnd} : '0);
    mul_next = {mul_sum, prod[WIDTH-1:1]};

    div_shift = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
    div_diff  = div_shift - {1'b0, opnd};
    // A borrow out of the top bit means the divisor did not fit: restore.
    div_next  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                : {div_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};

    prod_neg = -prod;
    if (is_div) begin
      fin_lo = neg_lo ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
      fin_hi = neg_hi ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end else begin
      fin_lo = neg_lo ? prod_neg[WIDTH-1:0] : prod[WIDTH-1:0];
      fin_hi = neg_lo ? prod_neg[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (bus.start) state_nx = (bus.op[1] && b_zero) ? FIN : CALC;
      CALC: if (count == CW'(WIDTH - 1)) state_nx = FIN;
      FIN:  if (!dz_hold) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      count    <= '0;
      prod     <= '0;
      opnd     <= '0;
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      dz_hold  <= 1'b0;
      bus.hi   <= '0;
      bus.lo   <= '0;
      bus.done <= 1'b0;
    end else begin
      state    <= state_nx;
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.hi_we) bus.hi <= bus.wdata;
          if (bus.lo_we) bus.lo <= bus.wdata;
          if (bus.start) begin
            count  <= '0;
            is_div <= bus.op[1];
            neg_lo <= a_neg ^ b_neg;
            neg_hi <= a_neg;
            if (bus.op[1]) begin
              opnd <= mag_b;
              if (b_zero) begin
                // Final answer preloaded unsigned: HI keeps a, LO all ones.
                prod    <= {bus.a, {WIDTH{1'b1}}};
                neg_lo  <= 1'b0;
                neg_hi  <= 1'b0;
                dz_hold <= 1'b1;
              end else begin
                prod <= {{WIDTH{1'b0}}, mag_a};
              end
            end else begin
              opnd <= mag_a;
              prod <= {{WIDTH{1'b0}}, mag_b};
            end
          end
        end
        CALC: begin
          count <= count + CW'(1);
          prod  <= is_div ? div_next : mul_next;
        end
        FIN: begin
          if (dz_hold) begin
            dz_hold <= 1'b0;
          end else begin
            bus.hi   <= fin_hi;
            bus.lo   <= fin_lo;
            bus.done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - self-checking bench for muldiv_unit at WIDTH 32 and WIDTH 8
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  muldiv_unit_if #(.WIDTH(32)) bus32 ();
  muldiv_unit_if #(.WIDTH(8))  bus8 ();

  muldiv_unit #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
  muldiv_unit #(.WIDTH(8))  dut8  (.clk(clk), .rst(rst), .bus(bus8));

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  // Architectural model per unit (0: WIDTH 32, 1: WIDTH 8)
  int          wid[2] = '{32, 8};
  logic [31:0] m_hi[2], m_lo[2], p_hi[2], p_lo[2];
  bit          pend[2];
  int          p_done[2];
  int          done_at[2] = '{-10, -10};

  function automatic logic [31:0] mask_of(input int w);
    return (w == 32) ? 32'hFFFF_FFFF : 32'((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, got, exp);
    end
  endtask

  // Reference arithmetic on w-bit two's-complement values using 64-bit integers.
  function automatic void ref_op(input int w, input logic [1:0] o, input logic [31:0] av,
                                 input logic [31:0] bv, output logic [31:0] rh,
                                 output logic [31:0] rl);
    logic [63:0] m, ua, ub, p;
    longint      sa, sb, q, r;
    m  = {32'd0, mask_of(w)};
    ua = {32'd0, av} & m;
    ub = {32'd0, bv} & m;
    sa = longint'(ua << (64 - w)) >>> (64 - w);
    sb = longint'(ub << (64 - w)) >>> (64 - w);
    rh = '0;
    rl = '0;
    p  = '0;
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = ua * ub;
      default: begin
        if (ub == 64'd0) begin
          rh = 32'(ua);
          rl = mask_of(w);
        end else if (o == 2'b10) begin
          q  = sa / sb;
          r  = sa % sb;
          rh = 32'(64'(r) & m);
          rl = 32'(64'(q) & m);
        end else begin
          rh = 32'(ua % ub);
          rl = 32'(ua / ub);
        end
      end
    endcase
    if (!o[1]) begin
      rh = 32'((p >> w) & m);
      rl = 32'(p & m);
    end
  endfunction

  task automatic model_step(input int u, input logic r, input logic st, input logic [1:0] o,
                            input logic [31:0] av, input logic [31:0] bv, input logic hwe,
                            input logic lwe, input logic [31:0] wd);
    logic [31:0] m;
    m = mask_of(wid[u]);
    if (r) begin
      m_hi[u]    = '0;
      m_lo[u]    = '0;
      pend[u]    = 1'b0;
      done_at[u] = -10;
    end else if (pend[u]) begin
      if (cyc == p_done[u]) begin
        m_hi[u]    = p_hi[u];
        m_lo[u]    = p_lo[u];
        pend[u]    = 1'b0;
        done_at[u] = cyc;
      end
    end else begin
      if (hwe) m_hi[u] = wd & m;
      if (lwe) m_lo[u] = wd & m;
      if (st) begin
        ref_op(wid[u], o, av, bv, p_hi[u], p_lo[u]);
        pend[u]   = 1'b1;
        p_done[u] = cyc + ((o[1] && ((bv & m) == 32'd0)) ? 2 : wid[u] + 1);
      end
    end
  endtask

  task automatic check_unit(input int u, input logic busy, input logic done,
                            input logic [31:0] h, input logic [31:0] l);
    chk($sformatf("u%0d_busy@%0d", u, cyc), {63'd0, busy}, {63'd0, pend[u]});
    chk($sformatf("u%0d_done@%0d", u, cyc), {63'd0, done}, {63'd0, done_at[u] == cyc});
    chk($sformatf("u%0d_hi@%0d", u, cyc), {32'd0, h}, {32'd0, m_hi[u]});
    chk($sformatf("u%0d_lo@%0d", u, cyc), {32'd0, l}, {32'd0, m_lo[u]});
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step(0, rst, bus32.start, bus32.op, bus32.a, bus32.b, bus32.hi_we, bus32.lo_we,
               bus32.wdata);
    model_step(1, rst, bus8.start, bus8.op, {24'd0, bus8.a}, {24'd0, bus8.b}, bus8.hi_we,
               bus8.lo_we, {24'd0, bus8.wdata});
  end

  initial forever begin
    @(negedge clk);
    if (check_en) begin
      check_unit(0, bus32.busy, bus32.done, bus32.hi, bus32.lo);
      check_unit(1, bus8.busy, bus8.done, {24'd0, bus8.hi}, {24'd0, bus8.lo});
    end
  end

  task automatic drive(input int u, input logic st, input logic [1:0] o, input logic [31:0] av,
                       input logic [31:0] bv, input logic hwe, input logic lwe,
                       input logic [31:0] wd);
    if (u == 0) begin
      bus32.start = st; bus32.op = o; bus32.a = av; bus32.b = bv;
      bus32.hi_we = hwe; bus32.lo_we = lwe; bus32.wdata = wd;
    end else begin
      bus8.start = st; bus8.op = o; bus8.a = av[7:0]; bus8.b = bv[7:0];
      bus8.hi_we = hwe; bus8.lo_we = lwe; bus8.wdata = wd[7:0];
    end
  endtask

  task automatic idle(input int u);
    drive(u, 1'b0, 2'b00, 32'd0, 32'd0, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic get_done(input int u);
    return (u == 0) ? bus32.done : bus8.done;
  endfunction

  function automatic logic [31:0] get_hi(input int u);
    return (u == 0) ? bus32.hi : {24'd0, bus8.hi};
  endfunction

  function automatic logic [31:0] get_lo(input int u);
    return (u == 0) ? bus32.lo : {24'd0, bus8.lo};
  endfunction

  task automatic start_op(input int u, input logic [1:0] o, input logic [31:0] av,
                          input logic [31:0] bv, output int t0);
    drive(u, 1'b1, o, av, bv, 1'b0, 1'b0, 32'd0);
    step();
    t0 = cyc;
    idle(u);
  endtask

  // Waits for done; with junk set, throws ignored starts/writes at the busy unit.
  task automatic wait_done(input int u, input int t0, input bit junk, output int lat);
    lat = -1;
    for (int i = 0; i < 80; i++) begin
      step();
      if (get_done(u)) begin
        lat = cyc - t0;
        break;
      end
      if (junk)
        drive(u, 1'($urandom), 2'($urandom), $urandom, $urandom, 1'($urandom),
              1'($urandom), $urandom);
    end
    idle(u);
    if (lat < 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL u%0d_timeout: done not seen within 80 cycles, required within %0d", u,
               wid[u] + 1);
    end
  endtask

  function automatic logic [31:0] rand_opnd(input int w);
    case ($urandom_range(0, 5))
      0: return 32'd0;
      1: return 32'd1;
      2: return mask_of(w);
      3: return 32'd1 << (w - 1);
      default: return $urandom & mask_of(w);
    endcase
  endfunction

  task automatic run_lit(input int u, input string nm, input logic [1:0] o,
                         input logic [31:0] av, input logic [31:0] bv, input int exp_lat,
                         input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int t0, lat;
    start_op(u, o, av, bv, t0);
    wait_done(u, t0, 1'b0, lat);
    chk({nm, "_lat"}, 64'(lat), 64'(exp_lat));
    chk({nm, "_hi"}, {32'd0, get_hi(u)}, {32'd0, exp_hi});
    chk({nm, "_lo"}, {32'd0, get_lo(u)}, {32'd0, exp_lo});
  endtask

  initial begin
    int t0, lat;
    logic [31:0] rh, rl, av, bv;
    logic [1:0] o;

    idle(0);
    idle(1);
    step();
    check_en = 1'b1;
    chk("rst_busy", {63'd0, bus32.busy}, 64'd0);
    chk("rst_done", {63'd0, bus32.done}, 64'd0);
    chk("rst_hi", {32'd0, bus32.hi}, 64'd0);
    chk("rst_lo", {32'd0, bus32.lo}, 64'd0);
    rst = 1'b0;
    step();

    // Pin the reference model to hand-computed values
    ref_op(32, 2'b00, 32'hFFFF_FFFD, 32'd5, rh, rl);
    chk("model_mult_hi", {32'd0, rh}, 64'hFFFF_FFFF);
    chk("model_mult_lo", {32'd0, rl}, 64'hFFFF_FFF1);
    ref_op(8, 2'b10, 32'h80, 32'hFF, rh, rl);
    chk("model_div8_lo", {32'd0, rl}, 64'h80);
    chk("model_div8_hi", {32'd0, rh}, 64'h0);
    ref_op(32, 2'b11, 32'd100, 32'd7, rh, rl);
    chk("model_divu_lo", {32'd0, rl}, 64'd14);

    run_lit(0, "multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33, 32'hFFFF_FFFE, 32'h1);
    run_lit(0, "mult_m3x5", 2'b00, 32'hFFFF_FFFD, 32'd5, 33, 32'hFFFF_FFFF, 32'hFFFF_FFF1);
    run_lit(0, "div_m7d2", 2'b10, 32'hFFFF_FFF9, 32'd2, 33, 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_lit(0, "divu_by0", 2'b11, 32'd7, 32'd0, 2, 32'd7, 32'hFFFF_FFFF);
    run_lit(0, "div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h0, 32'h8000_0000);
    run_lit(0, "mult_minsq", 2'b00, 32'h8000_0000, 32'h8000_0000, 33, 32'h4000_0000, 32'h0);

    // Reset in the middle of an operation
    start_op(0, 2'b01, 32'd12345, 32'd6789, t0);
    repeat (10) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_busy", {63'd0, bus32.busy}, 64'd0);
    chk("abort_done", {63'd0, bus32.done}, 64'd0);
    chk("abort_hi", {32'd0, bus32.hi}, 64'd0);
    chk("abort_lo", {32'd0, bus32.lo}, 64'd0);
    run_lit(0, "divu_100_7", 2'b11, 32'd100, 32'd7, 33, 32'd2, 32'd14);

    // Start and mthi while busy are ignored
    start_op(0, 2'b01, 32'd1000, 32'd3, t0);
    repeat (5) step();
    drive(0, 1'b1, 2'b10, 32'd9, 32'd9, 1'b1, 1'b1, 32'hDEAD);
    step();
    idle(0);
    wait_done(0, t0, 1'b0, lat);
    chk("ignore_lat", 64'(lat), 64'd33);
    chk("ignore_hi", {32'd0, bus32.hi}, 64'd0);
    chk("ignore_lo", {32'd0, bus32.lo}, 64'd3000);
    drive(0, 1'b0, 2'b00, 32'd0, 32'd0, 1'b1, 1'b0, 32'h1234);
    step();
    idle(0);
    chk("mthi_hi", {32'd0, bus32.hi}, 64'h1234);
    chk("mthi_lo", {32'd0, bus32.lo}, 64'd3000);

    // Writes and start in the same idle cycle: writes land, then FIN overwrites
    drive(0, 1'b1, 2'b00, 32'd2, 32'd3, 1'b1, 1'b1, 32'h5555);
    step();
    t0 = cyc;
    idle(0);
    chk("wstart_hi_mid", {32'd0, bus32.hi}, 64'h5555);
    wait_done(0, t0, 1'b0, lat);
    chk("wstart_hi", {32'd0, bus32.hi}, 64'd0);
    chk("wstart_lo", {32'd0, bus32.lo}, 64'd6);

    run_lit(1, "w8_minsq", 2'b00, 32'h80, 32'h80, 9, 32'h40, 32'h00);
    run_lit(1, "w8_divu0", 2'b11, 32'h5A, 32'h00, 2, 32'h5A, 32'hFF);

    // Randomized operations against the model on both widths
    for (int u = 0; u < 2; u++) begin
      for (int k = 0; k < 60; k++) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(u, 1'b0, 2'b00, 32'd0, 32'd0, 1'($urandom), 1'($urandom), $urandom);
          step();
          idle(u);
        end
        o  = 2'($urandom);
        av = rand_opnd(wid[u]);
        bv = rand_opnd(wid[u]);
        start_op(u, o, av, bv, t0);
        wait_done(u, t0, 1'b1, lat);
        chk($sformatf("u%0d_rand_lat%0d", u, k), 64'(lat),
            64'((o[1] && bv == 32'd0) ? 2 : wid[u] + 1));
      end
    end

    step();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
